// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: sequencer for a multi-operand carry-save accumulator.
// Each accepted operand goes through one 3:2 compression into a registered
// (sum, carry) pair. After the last operand, one carry-propagate add resolves
// the pair, and the result is offered on a valid/ready output.
// Optional build macro: CSA_ACCUM_SIGNED_EN (sign-extend operands instead of
// zero-extending them).
module csa_accum_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StAccum, StResolve, StDone} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] s_q, s_d;
   logic [ACC_W-1:0] c_q, c_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [ACC_W-1:0] x;
   logic [ACC_W-1:0] maj;

`ifdef CSA_ACCUM_SIGNED_EN
   assign x = ACC_W'($signed(in_data));
`else
   assign x = ACC_W'(in_data);
`endif

   // The majority term is stored pre-shifted, so S + C always equals the running total.
   assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

   assign busy    = (state_q != StIdle);
   assign out_sum = sum_q;

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      s_d       = s_q;
      c_d       = c_q;
      sum_d     = sum_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (len != '0) begin
                  cnt_d   = len;
                  s_d     = '0;
                  c_d     = '0;
                  state_d = StAccum;
               end else begin
                  // An empty stream goes straight to the output with a zero result.
                  sum_d   = '0;
                  state_d = StDone;
               end
            end
         end
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               s_d   = s_q ^ c_q ^ x;
               c_d   = maj << 1;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = StResolve;
               end
            end
         end
         StResolve: begin
            sum_d   = s_q + c_q;
            state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset drops any in-flight stream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         s_q     <= '0;
         c_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
      end
   end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: randomized self-checking bench for csa_accum_ctrl.
// The expected result is the plain arithmetic sum of the operand list
// (sign-extended when CSA_ACCUM_SIGNED_EN is defined), taken modulo 2^ACC_W.
module tb_csa_accum_ctrl;

   localparam int WIDTH = 16;
   localparam int CNT_W = 8;
   localparam int ACC_W = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic             busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] ops[$];

   csa_accum_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: the arithmetic sum of the operand list
   function automatic logic [ACC_W-1:0] model_sum();
      longint acc = 0;
      foreach (ops[i]) begin
`ifdef CSA_ACCUM_SIGNED_EN
         acc += longint'($signed(ops[i]));
`else
         acc += longint'(ops[i]);
`endif
      end
      return ACC_W'(acc);
   endfunction

   // Runs one stream from ops. vprob: percent chance of in_valid per cycle, or -1 to
   // toggle in_valid every cycle. lat counts falling edges after the edge that sampled
   // the last operand (or the start, for an empty stream) until out_valid is seen.
   task automatic drive_stream(input int n, input int vprob, input int rhold,
                               input int inject_at, output logic [ACC_W-1:0] res,
                               output int lat, output bit stable, output bit ok);
      int idx   = 0;
      int guard = 0;
      ok     = 1'b1;
      stable = 1'b1;
      lat    = 1;
      res    = '0;
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b1;
      len       = CNT_W'(n);
      in_valid  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (idx < n && guard < 4000) begin
         if (vprob < 0) in_valid = ~in_valid;
         else in_valid = (vprob >= 100) || ($urandom_range(99) < vprob);
         in_data   = ops[idx];
         out_ready = 1'($urandom_range(1));
         if (idx == inject_at) begin
            start = 1'b1;
            len   = CNT_W'(200);
         end else begin
            start = 1'b0;
         end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
         guard++;
      end
      if (guard >= 4000) ok = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = WIDTH'($urandom);
      out_ready = 1'b0;
      guard     = 0;
      while (!out_valid && guard < 100) begin
         @(negedge clk);
         lat++;
         guard++;
      end
      if (!out_valid) ok = 1'b0;
      res = out_sum;
      for (int i = 0; i < rhold; i++) begin
         in_data = WIDTH'($urandom);
         @(negedge clk);
         if (!out_valid || out_sum !== res) stable = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got ready=%b valid=%b busy=%b, want 0 0 0",
                  in_ready, out_valid, busy);
      end
      vectors++;
      if (out_sum !== '0) begin
         miscompares++;
         $display("FAIL reset_sum: got %h, want 0", out_sum);
      end
      rst = 1'b0;
      // Mid-stream reset: two of five operands accepted, then reset
      @(negedge clk);
      start = 1'b1;
      len   = CNT_W'(5);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'd11;
      @(negedge clk);
      in_data = 16'd22;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midstream_busy: got busy=%b ready=%b, want 1 1", busy, in_ready);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got ready=%b valid=%b busy=%b, want 0 0 0",
                  in_ready, out_valid, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
      end
      ops = {16'd7};
      drive_stream(1, 100, 0, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== model_sum()) begin
         miscompares++;
         $display("FAIL restart_after_reset: got %h ok=%b, want %h", res, ok, model_sum());
      end
   endtask

   task automatic test_basic();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      ops = {16'h0001, 16'h00FF, 16'hFFFF};
      drive_stream(3, 100, 0, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== model_sum()) begin
         miscompares++;
         $display("FAIL basic_sum: got %h ok=%b, want %h", res, ok, model_sum());
      end
`ifndef CSA_ACCUM_SIGNED_EN
      vectors++;
      if (res !== 24'h0100FF) begin
         miscompares++;
         $display("FAIL basic_const: got %h, want 0100ff", res);
      end
`endif
      vectors++;
      if (lat !== 2) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d, want 2", lat);
      end
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_idle_after: got busy=%b valid=%b, want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      ops = {16'd10, 16'd20, 16'd30, 16'd40};
      drive_stream(4, -1, 5, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== model_sum() || res !== 24'd100) begin
         miscompares++;
         $display("FAIL backpressure_sum: got %0d ok=%b, want 100", res, ok);
      end
      vectors++;
      if (!stable) begin
         miscompares++;
         $display("FAIL backpressure_hold: got unstable output, want stable %0d", res);
      end
      vectors++;
      if (lat !== 2) begin
         miscompares++;
         $display("FAIL backpressure_latency: got %0d, want 2", lat);
      end
   endtask

   task automatic test_len_zero_and_start_busy();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      ops = {};
      drive_stream(0, 100, 1, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== '0) begin
         miscompares++;
         $display("FAIL len_zero_sum: got %h ok=%b, want 0", res, ok);
      end
      vectors++;
      if (lat !== 1) begin
         miscompares++;
         $display("FAIL len_zero_latency: got %0d, want 1", lat);
      end
      ops = {16'd5, 16'd6, 16'd9};
      drive_stream(3, 60, 0, 1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== model_sum() || lat !== 2) begin
         miscompares++;
         $display("FAIL start_while_busy: got %h lat=%0d ok=%b, want %h lat=2",
                  res, lat, ok, model_sum());
      end
   endtask

   task automatic test_wrap();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      ops = {};
      for (int i = 0; i < 255; i++) ops.push_back(16'hFFFF);
      drive_stream(255, 100, 0, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== model_sum()) begin
         miscompares++;
         $display("FAIL wrap_sum: got %h ok=%b, want %h", res, ok, model_sum());
      end
`ifndef CSA_ACCUM_SIGNED_EN
      vectors++;
      if (res !== 24'hFEFF01) begin
         miscompares++;
         $display("FAIL wrap_const: got %h, want feff01", res);
      end
`endif
   endtask

   task automatic test_sign_mix();
      logic [ACC_W-1:0] res;
      logic [ACC_W-1:0] want;
      int lat;
      bit stable, ok;
`ifdef CSA_ACCUM_SIGNED_EN
      want = 24'hFF8002;
`else
      want = 24'h018002;
`endif
      ops = {16'hFFFF, 16'h0003, 16'h8000};
      drive_stream(3, 100, 0, -1, res, lat, stable, ok);
      vectors++;
      if (!ok || res !== want || res !== model_sum()) begin
         miscompares++;
         $display("FAIL sign_mix: got %h ok=%b, want %h", res, ok, want);
      end
   endtask

   task automatic test_random();
      logic [ACC_W-1:0] res;
      int lat;
      bit stable, ok;
      int n;
      for (int t = 0; t < 25; t++) begin
         n   = int'($urandom_range(12));
         ops = {};
         for (int i = 0; i < n; i++) ops.push_back(WIDTH'($urandom));
         drive_stream(n, 70, int'($urandom_range(3)), -1, res, lat, stable, ok);
         vectors++;
         if (!ok || !stable || res !== model_sum()) begin
            miscompares++;
            $display("FAIL random_%0d: got %h ok=%b stable=%b, want %h (len %0d)",
                     t, res, ok, stable, model_sum(), n);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_len_zero_and_start_busy();
      test_wrap();
      test_sign_mix();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
